// File: rtl/vga_block_render_pkg.sv
// vga_block_render_pkg: shared timing defaults, cell geometry, cell state codes and colours
package vga_block_render_pkg;
    localparam int H_ACT_DEF = 640;
    localparam int H_FP_DEF = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF = 48;
    localparam int V_ACT_DEF = 480;
    localparam int V_FP_DEF = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF = 33;
    localparam int CELL = 32;
    localparam int CELL_BITS = $clog2(CELL);
    localparam int GRID_W = 20;
    localparam int GRID_H = 15;

    typedef enum logic [3:0] {
        ST_EMPTY = 4'd0,
        ST_BODY = 4'd1,
        ST_HEAD = 4'd2,
        ST_FOOD = 4'd3,
        ST_WALL = 4'd4
    } cell_state_t;

    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_BODY = 12'h0C0;
    localparam logic [11:0] RGB_HEAD = 12'hFF0;
    localparam logic [11:0] RGB_FOOD = 12'hF00;
    localparam logic [11:0] RGB_WALL = 12'h888;
    localparam logic [11:0] RGB_OTHER = 12'hF0F;
    localparam logic [11:0] RGB_GRID = 12'h333;
    localparam logic [11:0] RGB_WHITE = 12'hFFF;

    function automatic logic [11:0] cell_rgb(input logic [3:0] s);
        return s == ST_EMPTY ? RGB_BLACK :
               s == ST_BODY  ? RGB_BODY  :
               s == ST_HEAD  ? RGB_HEAD  :
               s == ST_FOOD  ? RGB_FOOD  :
               s == ST_WALL  ? RGB_WALL  : RGB_OTHER;
    endfunction
endpackage

// File: rtl/vga_block_render_if.sv
// vga_block_render_if: cell address out to the grid register, cell state back
interface vga_block_render_if;
    logic [4:0] xBlockNum;
    logic [4:0] yBlockNum;
    logic [3:0] BlockState;
    modport master (output xBlockNum, yBlockNum, input BlockState);
    modport slave (input xBlockNum, yBlockNum, output BlockState);
endinterface

// File: rtl/vga_block_render_timing.sv
// vga_timing: pixel-rate divider, h/v scan counters, raw sync and active-area flag
module vga_timing
    import vga_block_render_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_ACT = H_ACT_DEF,
    parameter int H_FP = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP = H_BP_DEF,
    parameter int V_ACT = V_ACT_DEF,
    parameter int V_FP = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic       line_end,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       active,
    output logic       hs_raw,
    output logic       vs_raw
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    logic [DW-1:0] div;
    logic h_last, v_last;

    assign pix_en = div == DW'(CLK_DIV - 1);
    assign h_last = hcnt == 10'(H_TOT - 1);
    assign v_last = vcnt == 10'(V_TOT - 1);
    assign line_end = pix_en && h_last;
    assign active = hcnt < 10'(H_ACT) && vcnt < 10'(V_ACT);
    assign hs_raw = !(hcnt >= 10'(H_ACT + H_FP) && hcnt < 10'(H_ACT + H_FP + H_SYNC));
    assign vs_raw = !(vcnt >= 10'(V_ACT + V_FP) && vcnt < 10'(V_ACT + V_FP + V_SYNC));

    // divider runs every clk; counters step once per pixel, vcnt at line wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= pix_en ? '0 : div + 1'b1;
            if (pix_en) hcnt <= h_last ? '0 : hcnt + 1'b1;
            if (line_end) vcnt <= v_last ? '0 : vcnt + 1'b1;
        end
    end
endmodule

// File: rtl/vga_block_render.sv
// vga_block_render: scans the screen, fetches cell state per pixel and paints 32x32 cells
module vga_block_render
    import vga_block_render_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_ACT = H_ACT_DEF,
    parameter int H_FP = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP = H_BP_DEF,
    parameter int V_ACT = V_ACT_DEF,
    parameter int V_FP = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP = V_BP_DEF
) (
    input  logic                clk,
    input  logic                rst,
    vga_block_render_if.master  grid,
    input  logic                over,
    input  logic                grid_en,
    output logic                hs,
    output logic                vs,
    output logic [3:0]          r,
    output logic [3:0]          g,
    output logic [3:0]          b,
    output logic                video_on,
    output logic                frame_tick
);
    logic pix_en, line_end, active, hs_raw, vs_raw, on_grid;
    logic [9:0] hcnt, vcnt;
    logic [11:0] rgb_n;

    vga_timing #(
        .CLK_DIV(CLK_DIV), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst(rst), .pix_en(pix_en), .line_end(line_end), .hcnt(hcnt), .vcnt(vcnt),
        .active(active), .hs_raw(hs_raw), .vs_raw(vs_raw)
    );

    assign grid.xBlockNum = active ? hcnt[9:CELL_BITS] : '0;
    assign grid.yBlockNum = active ? vcnt[9:CELL_BITS] : '0;
    assign on_grid = grid_en && (hcnt[CELL_BITS-1:0] == '0 || vcnt[CELL_BITS-1:0] == '0);

    // colour priority: blanking, then game-over, then grid lines, then the cell map
    always_comb begin
        rgb_n = !active ? RGB_BLACK :
                over    ? (grid.BlockState == ST_HEAD ? RGB_WHITE : RGB_FOOD) :
                on_grid ? RGB_GRID : cell_rgb(grid.BlockState);
    end

    // output stage registers the current pixel, so outputs trail the counters by one pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs <= 1'b1;
            vs <= 1'b1;
            video_on <= 1'b0;
            {r, g, b} <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= line_end && vcnt == 10'(V_ACT - 1);
            if (pix_en) begin
                hs <= hs_raw;
                vs <= vs_raw;
                video_on <= active;
                {r, g, b} <= rgb_n;
            end
        end
    end
endmodule

// File: tb/tb_vga_block_render.sv
// tb_vga_block_render: scoreboarded pixel stream check on a shrunken screen geometry
module tb_vga_block_render;
    localparam int CD = 2;
    localparam int HA = 128, HF = 2, HS = 4, HB = 2;
    localparam int VA = 96, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic hs, vs, von, ft;
        logic [11:0] rgb;
        logic [4:0] xb, yb;
    } exp_t;

    logic clk = 0, rst = 0, over = 0, grid_en = 0;
    logic hs, vs, video_on, frame_tick;
    logic [3:0] r, g, b;
    logic [3:0] grid [0:14][0:19];
    exp_t sb[$];
    int errors = 0, checks = 0, h = 0, v = 0, cyc = 0, ft_cnt = 0;
    int hs_fall = -1, vs_fall = -1;
    bit meas = 0;

    vga_block_render_if gif();

    vga_block_render #(
        .CLK_DIV(CD), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .grid(gif), .over(over), .grid_en(grid_en),
        .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .video_on(video_on), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) gif.BlockState <= grid[gif.yBlockNum][gif.xBlockNum];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (h=%0d v=%0d)", tag, act, exp, h, v);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (frame_tick) ft_cnt++;
    end

    always @(negedge hs) if (meas) begin
        if (hs_fall >= 0) check("hs_period", cyc - hs_fall, HT * CD);
        hs_fall = cyc;
    end
    always @(posedge hs) if (meas && hs_fall >= 0) check("hs_low", cyc - hs_fall, HS * CD);
    always @(negedge vs) if (meas) begin
        if (vs_fall >= 0) check("vs_period", cyc - vs_fall, HT * VT * CD);
        vs_fall = cyc;
    end
    always @(posedge vs) if (meas && vs_fall >= 0) check("vs_low", cyc - vs_fall, VS * HT * CD);

    function automatic logic [11:0] cmap(input int st);
        case (st)
            0: return 12'h000;
            1: return 12'h0C0;
            2: return 12'hFF0;
            3: return 12'hF00;
            4: return 12'h888;
            default: return 12'hF0F;
        endcase
    endfunction

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        bit act;
        int st;
        act = x < HA && y < VA;
        st = grid[y / 32][x / 32];
        e = '0;
        e.hs = !(x >= HA + HF && x < HA + HF + HS);
        e.vs = !(y >= VA + VF && y < VA + VF + VS);
        e.von = act;
        if (!act) e.rgb = 12'h000;
        else if (over) e.rgb = st == 2 ? 12'hFFF : 12'hF00;
        else if (grid_en && (x % 32 == 0 || y % 32 == 0)) e.rgb = 12'h333;
        else e.rgb = cmap(st);
        return e;
    endfunction

    task automatic run_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e, got;
            int nh, nv;
            nh = h == HT - 1 ? 0 : h + 1;
            nv = h == HT - 1 ? (v == VT - 1 ? 0 : v + 1) : v;
            e = model(h, v);
            e.ft = h == HT - 1 && v == VA - 1;
            e.xb = (nh < HA && nv < VA) ? 5'(nh / 32) : 5'd0;
            e.yb = (nh < HA && nv < VA) ? 5'(nv / 32) : 5'd0;
            sb.push_back(e);
            repeat (CD) @(posedge clk);
            #1;
            got = sb.pop_front();
            check("hs", hs, got.hs);
            check("vs", vs, got.vs);
            check("video_on", video_on, got.von);
            check("rgb", {r, g, b}, got.rgb);
            check("frame_tick", frame_tick, got.ft);
            check("xblk", gif.xBlockNum, got.xb);
            check("yblk", gif.yBlockNum, got.yb);
            h = nh;
            v = nv;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"}, hs, 1);
        check({tag, "_vs"}, vs, 1);
        check({tag, "_von"}, video_on, 0);
        check({tag, "_rgb"}, {r, g, b}, 0);
        check({tag, "_ft"}, frame_tick, 0);
        check({tag, "_xblk"}, gif.xBlockNum, 0);
        check({tag, "_yblk"}, gif.yBlockNum, 0);
    endtask

    task automatic fill_grid(input logic [3:0] s);
        for (int y = 0; y < 15; y++)
            for (int x = 0; x < 20; x++) grid[y][x] = s;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 0;
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1;
        h = 0;
        v = 0;
    endtask

    initial begin
        fill_grid(4'd0);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        grid[2][3] = 4'd2;
        ft_cnt = 0;
        meas = 1;
        release_reset();
        run_pixels(2 * HT * VT);
        meas = 0;
        check("ft_count", ft_cnt, 2);

        hold_reset();
        fill_grid(4'd0);
        grid[0][0] = 4'd2;
        grid[0][1] = 4'd3;
        over = 1;
        grid_en = 1;
        release_reset();
        run_pixels(64);
        over = 0;
        run_pixels(80);

        hold_reset();
        fill_grid(4'd1);
        grid_en = 1;
        over = 0;
        release_reset();
        run_pixels(40 * HT + 100);
        check("pre_rst_von", video_on, 1);
        check("pre_rst_xblk", gif.xBlockNum, 3);
        #2;
        rst = 0;
        #1;
        check_reset_outputs("async");
        repeat (2) @(negedge clk);
        check_reset_outputs("held");
        release_reset();
        run_pixels(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
